// File: rtl/sd_capture_la_if.sv
// -----------------------------------------------------------------------------
// sd_capture_la_if
// Bus bundle for the sd_capture_la trigger-and-capture analyser.
//   master : the host/debug side. It drives the probe, qualifier and control
//            inputs and the read address, and observes the status and read data.
//   slave  : the analyser itself.
// Parameters:
//   DATA_W : probe bus width
//   ADDR_W : capture buffer address width ($clog2 of the analyser DEPTH)
// -----------------------------------------------------------------------------
interface sd_capture_la_if #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] data_i;
  logic              sample_en_i;
  logic              arm_i;
  logic              abort_i;
  logic [1:0]        trig_mode_i;
  logic [DATA_W-1:0] trig_mask_i;
  logic [DATA_W-1:0] trig_value_i;
  logic [ADDR_W-1:0] pretrig_i;
  logic [2:0]        state_o;
  logic              triggered_o;
  logic              done_o;
  logic [ADDR_W-1:0] trig_addr_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;

  modport master (
    output data_i, sample_en_i, arm_i, abort_i, trig_mode_i, trig_mask_i,
           trig_value_i, pretrig_i, rd_addr_i,
    input  state_o, triggered_o, done_o, trig_addr_o, rd_data_o
  );

  modport slave (
    input  data_i, sample_en_i, arm_i, abort_i, trig_mode_i, trig_mask_i,
           trig_value_i, pretrig_i, rd_addr_i,
    output state_o, triggered_o, done_o, trig_addr_o, rd_data_o
  );
endinterface

// File: rtl/sd_capture_la.sv
// -----------------------------------------------------------------------------
// sd_capture_la
// Trigger-and-capture logic analyser for the sigma-delta ADC datapath.
// Qualified probe samples go into a circular RAM. The block keeps a
// programmable number of samples from before the trigger. After the trigger it
// fills the rest of the buffer and then freezes. The frozen window is read
// through a logical address, where 0 is the oldest sample in the window.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : sd_capture_la_if.slave, which carries:
//                data_i/sample_en_i      probe bus and its sample qualifier
//                arm_i/abort_i           capture control pulses
//                trig_mode_i/mask/value  trigger set-up, latched on arm
//                pretrig_i               pre-trigger depth, latched on arm
//                state_o/triggered_o/done_o/trig_addr_o  status
//                rd_addr_i/rd_data_o     logical read port, 1-cycle latency
// -----------------------------------------------------------------------------
module sd_capture_la #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 256
) (
  input logic          clk,
  input logic          rst_n,
  sd_capture_la_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] prev_data_q, prev_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              prev_match_q, prev_match_d;
  logic              prev_valid_q, prev_valid_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;

  logic              qualified;
  logic              cur_match;
  logic              hit;
  logic              mem_we;
  logic [ADDR_W-1:0] post_load;
  logic [ADDR_W-1:0] rd_phys;

  logic [DATA_W-1:0] mem [DEPTH];

  // Trigger evaluation for the current probe sample. Mode 11 fires on any
  // qualified sample, and that only matters in WAIT.
  always_comb begin
    qualified = bus.sample_en_i &&
                ((state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST));
    cur_match = ((bus.data_i ^ value_q) & mask_q) == '0;
    post_load = LAST_ADDR - pretrig_q;
    // The window starts pretrig samples before the trigger, modulo DEPTH.
    rd_phys   = trig_addr_q - pretrig_q + bus.rd_addr_i;
    case (mode_q)
      2'b00:   hit = cur_match;
      2'b01:   hit = cur_match && prev_valid_q && !prev_match_q;
      2'b10:   hit = prev_valid_q && (((bus.data_i ^ prev_data_q) & mask_q) != '0);
      default: hit = 1'b1;
    endcase
  end

  // Next-state logic. Priority order is abort, then arm, then a qualified sample.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    pretrig_d    = pretrig_q;
    trig_addr_d  = trig_addr_q;
    mode_d       = mode_q;
    mask_d       = mask_q;
    value_d      = value_q;
    prev_data_d  = prev_data_q;
    prev_match_d = prev_match_q;
    prev_valid_d = prev_valid_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    mem_we       = 1'b0;
    rd_data_d    = mem[rd_phys];

    if (bus.abort_i) begin
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      triggered_d = 1'b0;
    end else if (bus.arm_i) begin
      mode_d       = bus.trig_mode_i;
      mask_d       = bus.trig_mask_i;
      value_d      = bus.trig_value_i;
      pretrig_d    = bus.pretrig_i;
      wptr_d       = '0;
      pre_cnt_d    = '0;
      triggered_d  = 1'b0;
      done_d       = 1'b0;
      prev_valid_d = 1'b0;
      state_d      = (bus.pretrig_i == '0) ? ST_WAIT : ST_PRE;
    end else if (qualified) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + ONE_ADDR;
      // Only PRE and WAIT samples feed the history used by edge/change modes.
      if (state_q != ST_POST) begin
        prev_data_d  = bus.data_i;
        prev_match_d = cur_match;
        prev_valid_d = 1'b1;
      end
      case (state_q)
        ST_PRE: begin
          if ((pre_cnt_q + ONE_ADDR) == pretrig_q) begin
            state_d = ST_WAIT;
          end
          pre_cnt_d = pre_cnt_q + ONE_ADDR;
        end
        ST_WAIT: begin
          if (hit) begin
            trig_addr_d = wptr_q;
            triggered_d = 1'b1;
            post_cnt_d  = post_load;
            if (post_load == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          post_cnt_d = post_cnt_q - ONE_ADDR;
          if (post_cnt_q == ONE_ADDR) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      pretrig_q    <= '0;
      trig_addr_q  <= '0;
      mode_q       <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      prev_data_q  <= '0;
      prev_match_q <= 1'b0;
      prev_valid_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      pretrig_q    <= pretrig_d;
      trig_addr_q  <= trig_addr_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      prev_data_q  <= prev_data_d;
      prev_match_q <= prev_match_d;
      prev_valid_q <= prev_valid_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // The capture RAM has no reset. Its contents are only meaningful once done_o is set.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_q] <= bus.data_i;
    end
  end

  assign bus.state_o     = state_q;
  assign bus.triggered_o = triggered_q;
  assign bus.done_o      = done_q;
  assign bus.trig_addr_o = trig_addr_q;
  assign bus.rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_sd_capture_la.sv
// -----------------------------------------------------------------------------
// tb_sd_capture_la
// Self-checking bench for sd_capture_la with DEPTH=16 and DATA_W=8.
// The reference model keeps the list of every qualified sample since arm. The
// trigger index is found from the trigger rules applied to that list. The
// expected state follows from how many samples have been taken. The read-back
// window is the slice of the list around the trigger.
// -----------------------------------------------------------------------------
module tb_sd_capture_la;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sd_capture_la_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  sd_capture_la #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Stop a runaway simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int mode;
    int mask;
    int value;
    int pretrig;
    int enEvery;
    int pat;
    int expTrigAddr;
    int expRead0;
    int expRead15;
  } vec_t;

  vec_t vecs[7];

  // Reference model state.
  int         mMode, mMask, mValue, mPretrig;
  logic [7:0] samples[$];
  int         tIdx;
  bit         mIdle = 1'b1;

  function automatic bit mMatch(logic [7:0] d);
    return ((int'(d) ^ mValue) & mMask & 'hFF) == 0;
  endfunction

  function automatic bit mHit(int k);
    case (mMode)
      0:       return mMatch(samples[k]);
      1:       return mMatch(samples[k]) && (k > 0) && !mMatch(samples[k-1]);
      2:       return (k > 0) && (((int'(samples[k]) ^ int'(samples[k-1])) & mMask & 'hFF) != 0);
      default: return k == mPretrig;
    endcase
  endfunction

  function automatic int modelState();
    int n;
    n = samples.size();
    if (mIdle) return 0;
    if (tIdx < 0) return (n < mPretrig) ? 1 : 2;
    if (n >= tIdx + DEPTH - mPretrig) return 4;
    return 3;
  endfunction

  function automatic void modelPush(logic [7:0] d);
    int k;
    k = samples.size();
    samples.push_back(d);
    if (tIdx < 0 && k >= mPretrig && mHit(k)) tIdx = k;
  endfunction

  // Probe patterns indexed by cycle since arm. c = -1 is the arm cycle itself.
  function automatic logic [7:0] patData(int pat, int c);
    case (pat)
      0:       return 8'(c);
      1:       return 8'((c << 1) | ((c == 5) ? 0 : 1));
      2:       return (c < 7) ? 8'h11 : 8'h91;
      default: return 8'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit en, input bit arm, input bit abort);
    bus.data_i      = d;
    bus.sample_en_i = en;
    bus.arm_i       = arm;
    bus.abort_i     = abort;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic armCapture(input int mode, input int mask, input int value, input int pretrig, input int pat);
    mMode = mode; mMask = mask; mValue = value; mPretrig = pretrig;
    samples.delete();
    tIdx  = -1;
    mIdle = 1'b0;
    bus.trig_mode_i  = 2'(mode);
    bus.trig_mask_i  = 8'(mask);
    bus.trig_value_i = 8'(value);
    bus.pretrig_i    = 4'(pretrig);
    applyStimulus(patData(pat, -1), 1'b1, 1'b1, 1'b0);
    tick();
    // Scramble the set-up inputs. The capture must keep the values latched on arm.
    bus.trig_mode_i  = ~bus.trig_mode_i;
    bus.trig_mask_i  = ~bus.trig_mask_i;
    bus.trig_value_i = ~bus.trig_value_i;
    bus.pretrig_i    = bus.pretrig_i + 4'd5;
    checkOutput("arm_state", int'(bus.state_o), modelState());
    checkOutput("arm_triggered", int'(bus.triggered_o), 0);
    checkOutput("arm_done", int'(bus.done_o), 0);
  endtask

  task automatic stepCycle(input logic [7:0] d, input bit en);
    int s;
    s = modelState();
    applyStimulus(d, en, 1'b0, 1'b0);
    tick();
    if (en && s != 0 && s != 4) modelPush(d);
    checkOutput("state", int'(bus.state_o), modelState());
    checkOutput("triggered", int'(bus.triggered_o), (!mIdle && tIdx >= 0) ? 1 : 0);
    checkOutput("done", int'(bus.done_o), (modelState() == 4) ? 1 : 0);
  endtask

  task automatic runCapture(input int mode, input int mask, input int value, input int pretrig,
                            input int enEvery, input int pat, input int budget, output bit gotDone);
    bit en;
    armCapture(mode, mask, value, pretrig, pat);
    gotDone = 1'b0;
    for (int c = 0; c < budget; c++) begin
      en = (enEvery > 0) ? ((c % enEvery) == 0) : ($urandom_range(0, 3) != 0);
      stepCycle(patData(pat, c), en);
      if (modelState() == 4) begin
        gotDone = 1'b1;
        break;
      end
    end
  endtask

  // Qualified samples keep arriving while reading, and DONE must ignore them.
  task automatic readWindow(output int r0, output int r15);
    r0 = -1;
    r15 = -1;
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      bus.rd_addr_i = 4'(a);
      tick();
      checkOutput("read", int'(bus.rd_data_o), int'(samples[tIdx - mPretrig + a]));
      checkOutput("done_hold", int'(bus.state_o), 4);
      if (a == 0) r0 = int'(bus.rd_data_o);
      if (a == DEPTH - 1) r15 = int'(bus.rd_data_o);
    end
  endtask

  initial begin
    bit gotDone;
    int r0, r15;

    vecs[0] = '{0, 'hFF, 'h0A, 4,  1, 0, 10, 'h06, 'h15};
    vecs[1] = '{1, 'h01, 'h01, 4,  1, 1, 6,  'h05, 'h23};
    vecs[2] = '{0, 'hFF, 'h1E, 4,  3, 0, 10, 'h12, 'h3F};
    vecs[3] = '{3, 'hFF, 'h00, 0,  1, 0, 0,  'h00, 'h0F};
    vecs[4] = '{0, 'h00, 'h5A, 4,  1, 0, 4,  'h00, 'h0F};
    vecs[5] = '{2, 'h80, 'h00, 0,  1, 2, 7,  'h91, 'h91};
    vecs[6] = '{0, 'hFF, 'h14, 15, 1, 0, 4,  'h05, 'h14};

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    bus.trig_mode_i  = '0;
    bus.trig_mask_i  = '0;
    bus.trig_value_i = '0;
    bus.pretrig_i    = '0;
    bus.rd_addr_i    = '0;

    // Reset state.
    #1;
    checkOutput("rst_state", int'(bus.state_o), 0);
    checkOutput("rst_done", int'(bus.done_o), 0);
    repeat (2) tick();
    checkOutput("rst_triggered", int'(bus.triggered_o), 0);
    checkOutput("rst_trig_addr", int'(bus.trig_addr_o), 0);
    checkOutput("rst_rd_data", int'(bus.rd_data_o), 0);
    rst_n = 1'b1;
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("idle_no_start", int'(bus.state_o), 0);

    // Directed capture table.
    for (int i = 0; i < 7; i++) begin
      runCapture(vecs[i].mode, vecs[i].mask, vecs[i].value, vecs[i].pretrig,
                 vecs[i].enEvery, vecs[i].pat, 200, gotDone);
      checkOutput("vec_done", int'(bus.done_o), 1);
      if (gotDone) begin
        checkOutput("vec_trig_addr", int'(bus.trig_addr_o), vecs[i].expTrigAddr);
        checkOutput("model_trig_addr", int'(bus.trig_addr_o), tIdx % DEPTH);
        readWindow(r0, r15);
        checkOutput("vec_read0", r0, vecs[i].expRead0);
        checkOutput("vec_read15", r15, vecs[i].expRead15);
      end
    end

    // Abort while in POST.
    armCapture(0, 'hFF, 'h0A, 4, 0);
    for (int c = 0; c < 12; c++) stepCycle(patData(0, c), 1'b1);
    checkOutput("seq_in_post", int'(bus.state_o), 3);
    applyStimulus(8'd12, 1'b1, 1'b0, 1'b1);
    tick();
    mIdle = 1'b1;
    checkOutput("abort_state", int'(bus.state_o), 0);
    checkOutput("abort_done", int'(bus.done_o), 0);
    checkOutput("abort_triggered", int'(bus.triggered_o), 0);

    // Arm and abort in the same cycle: abort wins.
    armCapture(0, 'hFF, 'h0A, 4, 0);
    for (int c = 0; c < 3; c++) stepCycle(patData(0, c), 1'b1);
    bus.pretrig_i = 4'd0;
    applyStimulus(8'd3, 1'b1, 1'b1, 1'b1);
    tick();
    mIdle = 1'b1;
    checkOutput("arm_abort_state", int'(bus.state_o), 0);
    checkOutput("arm_abort_triggered", int'(bus.triggered_o), 0);

    // Asynchronous reset in the middle of POST.
    armCapture(0, 'hFF, 'h0A, 4, 0);
    for (int c = 0; c < 12; c++) stepCycle(patData(0, c), 1'b1);
    checkOutput("pre_rst_trig_addr", int'(bus.trig_addr_o), 10);
    #1 rst_n = 1'b0;
    #1;
    mIdle = 1'b1;
    checkOutput("async_rst_state", int'(bus.state_o), 0);
    checkOutput("async_rst_triggered", int'(bus.triggered_o), 0);
    checkOutput("async_rst_done", int'(bus.done_o), 0);
    checkOutput("async_rst_trig_addr", int'(bus.trig_addr_o), 0);
    checkOutput("async_rst_rd_data", int'(bus.rd_data_o), 0);
    #1 rst_n = 1'b1;
    stepCycle(8'h44, 1'b1);

    // Re-arm from DONE: done_o clears on the next cycle.
    runCapture(0, 'hFF, 'h0A, 4, 1, 0, 200, gotDone);
    checkOutput("rearm_was_done", int'(bus.done_o), 1);
    armCapture(3, 'h00, 'h00, 2, 0);
    checkOutput("rearm_state", int'(bus.state_o), 1);
    for (int c = 0; c < 4; c++) stepCycle(patData(0, c), 1'b1);

    // Randomised captures against the model.
    for (int i = 0; i < 24; i++) begin
      runCapture($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 15), 0, 3, 150, gotDone);
      if (gotDone) begin
        checkOutput("rand_trig_addr", int'(bus.trig_addr_o), tIdx % DEPTH);
        readWindow(r0, r15);
      end else begin
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        mIdle = 1'b1;
        checkOutput("rand_abort_state", int'(bus.state_o), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
